// File: rtl/driver_pattern.sv
// driver_pattern: prescaled pattern generator (CONST/INV/ROTL/COUNT) with load; ports clk, rst, en, mode, load, din -> out, tick; `define DRIVER_PATTERN_SAT_EN makes COUNT saturate at all-ones
module driver_pattern #(
  parameter int WIDTH = 8,
  parameter int DIV = 4,
  parameter int INIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] out,
  output logic             tick
);
  localparam logic [15:0] last = 16'(DIV - 1);
  logic [15:0] cnt;
  logic [WIDTH-1:0] rot, inc, nxt;
  logic wrap;
  always_comb begin
    rot = (out << 1) | (out >> (WIDTH - 1));
`ifdef DRIVER_PATTERN_SAT_EN
    inc = &out ? out : out + WIDTH'(1);
`else
    inc = out + WIDTH'(1);
`endif
    nxt = mode == 2'b00 ? out : mode == 2'b01 ? ~out : mode == 2'b10 ? rot : inc;
    wrap = cnt == last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= WIDTH'(INIT);
      cnt <= '0;
      tick <= 1'b0;
    end else if (load) begin
      out <= din;
      cnt <= '0;
      tick <= 1'b0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 16'd1;
      tick <= wrap;
      if (wrap) out <= nxt;
    end else begin
      tick <= 1'b0;
    end
  end
endmodule

// File: tb/tb_driver_pattern.sv
// tb_driver_pattern: directed self-checking bench for driver_pattern (WIDTH=8, DIV=4, INIT=1)
module tb_driver_pattern;
  logic clk = 1'b0;
  logic rst, en, load;
  logic [1:0] mode;
  logic [7:0] din, out;
  logic tick;
  int n_assert = 0;
  int n_fail = 0;
  driver_pattern #(.WIDTH(8), .DIV(4), .INIT(1)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .din(din), .out(out), .tick(tick)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; mode = 2'b00; din = 8'h00;
    step(); step();
    check("rst_out", out, 8'h01);
    check("rst_tick", tick, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_out", out, 8'h01);
      check("idle_tick", tick, 0);
    end
    mode = 2'b10; en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      check("rotl_tick", tick, (k % 4 == 0) ? 1 : 0);
      check("rotl_out", out, 8'h01 << (k / 4));
    end
    rst = 1'b1; step(); rst = 1'b0;
    mode = 2'b01;
    for (int i = 0; i < 16; i++) begin
      en = (i % 2 == 0);
      step();
      check("inv_tick", tick, (i == 6 || i == 14) ? 1 : 0);
      check("inv_out", out, (i >= 6 && i < 14) ? 8'hFE : 8'h01);
    end
    mode = 2'b10; en = 1'b1;
    step(); step(); step();
    check("pre_load_out", out, 8'h01);
    load = 1'b1; din = 8'hA5;
    step();
    check("load_out", out, 8'hA5);
    check("load_tick", tick, 0);
    load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("post_load_tick", tick, 0);
    end
    step();
    check("post_load_tick4", tick, 1);
    check("post_load_out4", out, 8'h4B);
    load = 1'b1; din = 8'hFE;
    step();
    load = 1'b0; mode = 2'b11;
    step(); step(); step();
    check("cnt_pre_tick", tick, 0);
    check("cnt_pre_out", out, 8'hFE);
    step();
    check("cnt_tick1", tick, 1);
    check("cnt_out1", out, 8'hFF);
    step(); step(); step();
    check("cnt_mid_tick", tick, 0);
    step();
    check("cnt_tick2", tick, 1);
`ifdef DRIVER_PATTERN_SAT_EN
    check("cnt_out2_sat", out, 8'hFF);
`else
    check("cnt_out2_wrap", out, 8'h00);
`endif
    en = 1'b0;
    step();
    check("en0_tick", tick, 0);
    load = 1'b1; din = 8'h40; mode = 2'b00;
    step();
    load = 1'b0; en = 1'b1;
    step(); step();
    check("mid_out", out, 8'h40);
    rst = 1'b1; load = 1'b1; din = 8'hFF;
    step();
    check("midrst_out", out, 8'h01);
    check("midrst_tick", tick, 0);
    step();
    check("midrst_hold_out", out, 8'h01);
    rst = 1'b0; load = 1'b0; mode = 2'b10;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("rel_tick", tick, 0);
      check("rel_out", out, 8'h01);
    end
    step();
    check("rel_tick4", tick, 1);
    check("rel_out4", out, 8'h02);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/driver_pattern.md
DRIVER_PATTERN -- requirements
Module: driver_pattern

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the output width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter DIV, default 4, giving the prescaler period in enabled clock cycles (legal range 1..65535).
REQ-003 The block SHALL have parameter INIT, default 1, giving the pattern register reset value, truncated to WIDTH bits.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port en, input, 1 bit: prescaler advance enable.
REQ-007 The block SHALL have port mode, input, 2 bits: update mode, 00 CONST, 01 INV, 10 ROTL, 11 COUNT.
REQ-008 The block SHALL have port load, input, 1 bit: single-cycle load strobe.
REQ-009 The block SHALL have port din, input, WIDTH bits: load value.
REQ-010 The block SHALL have port out, output, WIDTH bits: the registered pattern value.
REQ-011 The block SHALL have port tick, output, 1 bit: registered pulse, high for the cycle in which out shows a tick-driven update.

Function
REQ-012 The prescaler SHALL count 0..DIV-1, advancing only in cycles with en=1 and load=0, and wrapping from DIV-1 to 0.
REQ-013 A tick event SHALL occur in a cycle with en=1, load=0 and prescaler=DIV-1; with DIV=1, every such cycle SHALL be a tick event.
REQ-014 On a tick event, out SHALL update at the next rising edge as follows: CONST holds; INV gives ~out; ROTL gives {out[WIDTH-2:0],out[WIDTH-1]}, with WIDTH=1 holding; COUNT gives out+1 modulo 2^WIDTH, subject to REQ-024.
REQ-015 tick SHALL be 1 in the cycle after a tick event and 0 otherwise, including in CONST mode.
REQ-016 With en=0, the prescaler and out SHALL hold, and tick SHALL be 0 in the following cycle.
REQ-017 With load=1, out SHALL take din at the next edge, the prescaler SHALL clear to 0, and tick SHALL be 0 in the following cycle; load SHALL override any coincident tick event, independent of en.
REQ-018 mode SHALL be sampled only at tick events, and a mode change SHALL NOT reset the prescaler.
REQ-019 out and tick SHALL be driven directly from flip-flops, with no combinational path from any input.

Reset
REQ-020 With rst=1 at a rising edge, out SHALL become INIT, the prescaler 0, and tick 0.
REQ-021 rst SHALL take priority over load, en and tick events.
REQ-022 Reset asserted mid-period SHALL discard the partial prescaler count, and the first tick after release SHALL occur DIV enabled cycles later.
REQ-023 Outputs SHALL hold reset values for as long as rst=1.

Configuration
REQ-024 With macro DRIVER_PATTERN_SAT_EN defined, COUNT mode SHALL saturate at all-ones, so a tick event with out=all-ones leaves out unchanged while tick still pulses; without the macro, COUNT SHALL wrap all-ones to 0.
REQ-025 DRIVER_PATTERN_SAT_EN SHALL affect only COUNT mode; CONST, INV, ROTL and load behaviour SHALL be identical with and without the macro.

Verification
Defaults for all scenarios: WIDTH=8, DIV=4, INIT=1.
REQ-026 Reset check: rst=1 for 2 cycles, then release with en=0 -> out=0x01 and tick=0 for 10 cycles.
REQ-027 ROTL period: mode=10, en=1 held for 16 cycles after reset -> tick on cycles 5, 9, 13 and 17, with out 0x02, 0x04, 0x08, 0x10.
REQ-028 INV with gated enable: mode=01, en toggling 1/0 each cycle -> out alternates 0xFE and 0x01 once every 8 clocks; tick lasts one cycle.
REQ-029 Load priority: load=1 with din=0xA5 in a tick-event cycle -> out=0xA5 with tick=0 in the next cycle, and the next tick comes 4 enabled cycles later.
REQ-030 COUNT at the boundary: load 0xFE, mode=11, en=1 -> out 0xFF, then 0x00 without the macro, or 0xFF with DRIVER_PATTERN_SAT_EN; tick pulses on both events.
REQ-031 Reset mid-operation: rst=1 with prescaler=2 and out=0x40 -> next cycle out=0x01 and tick=0; after release, the first tick comes 4 enabled cycles later.
